// File: rtl/axi_lite_slave_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_slave_regfile_if
//  Description : AXI4-Lite link bundle (AW, W, B, AR, R channels) between a
//                master and the register-file responder.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals (all active-high, sampled on the rising edge of the link clock):
//     AWADDR/AWVALID/AWREADY   write address channel
//     WDATA/WSTRB/WVALID/WREADY write data channel (WSTRB[k] -> byte k)
//     BRESP/BVALID/BREADY      write response channel
//     ARADDR/ARVALID/ARREADY   read address channel
//     RDATA/RRESP/RVALID/RREADY read data channel
//  Modports: master (drives VALIDs / READYs of response channels),
//            slave  (the mirror image).
// ============================================================================
interface axi_lite_slave_regfile_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] AWADDR;
   logic                  AWVALID;
   logic                  AWREADY;
   logic [31:0]           WDATA;
   logic [3:0]            WSTRB;
   logic                  WVALID;
   logic                  WREADY;
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [31:0]           RDATA;
   logic [1:0]            RRESP;
   logic                  RVALID;
   logic                  RREADY;

   modport master (
      output AWADDR, AWVALID, input  AWREADY,
      output WDATA, WSTRB, WVALID, input WREADY,
      input  BRESP, BVALID, output BREADY,
      output ARADDR, ARVALID, input ARREADY,
      input  RDATA, RRESP, RVALID, output RREADY
   );

   modport slave (
      input  AWADDR, AWVALID, output AWREADY,
      input  WDATA, WSTRB, WVALID, output WREADY,
      output BRESP, BVALID, input BREADY,
      input  ARADDR, ARVALID, output ARREADY,
      output RDATA, RRESP, RVALID, input RREADY
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_slave_regfile
//  Description : AXI4-Lite responder exposing NUM_REGS 32-bit read/write
//                registers at byte offsets 4*i. Independent write and read
//                state machines, byte strobes, SLVERR for addresses whose
//                word index is >= NUM_REGS. Register contents are also
//                driven out flat on regs_o.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports:
//     ACLK     in   rising-edge system clock
//     ARESETn  in   asynchronous active-low reset
//     s_axi    if   AXI4-Lite slave modport (AW, W, B, AR, R channels)
//     regs_o   out  register i at bits [32i+31:32i], no extra latency
// ============================================================================
module axi_lite_slave_regfile #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_REGS   = 4
) (
   input  wire                         ACLK,
   input  wire                         ARESETn,
   axi_lite_slave_regfile_if.slave     s_axi,
   output logic [32*NUM_REGS-1:0]      regs_o
);

   localparam logic [1:0] C_RESP_OKAY   = 2'b00;
   localparam logic [1:0] C_RESP_SLVERR = 2'b10;
   localparam logic [ADDR_WIDTH-1:0] C_NUM_REGS = ADDR_WIDTH'(NUM_REGS);

   // W_HALF covers "collecting": one channel captured, or both captured for
   // the single cycle before the commit edge.
   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_HALF = 2'd1,
      W_RESP = 2'd2
   } wstate_e;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_e;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [NUM_REGS-1:0][31:0] regs_q, regs_d;

   wstate_e               wstate_q, wstate_d;
   logic                  aw_held_q, aw_held_d;
   logic                  w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;

   rstate_e               rstate_q, rstate_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [31:0]           rdata_q, rdata_d;

   // ------------------------------------------------------------------------
   // Decode / handshakes
   // ------------------------------------------------------------------------
   logic [ADDR_WIDTH-3:0] w_widx;
   logic [ADDR_WIDTH-3:0] w_ridx;
   logic                  w_wr_in_range;
   logic                  w_rd_in_range;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_ar_hs;
   logic                  w_commit;
   logic [31:0]           w_rd_word;
   logic                  w_unused_addr_lsbs;

   assign w_widx = awaddr_q[ADDR_WIDTH-1:2];
   assign w_ridx = s_axi.ARADDR[ADDR_WIDTH-1:2];
   assign w_wr_in_range = ({2'b00, w_widx} < C_NUM_REGS);
   assign w_rd_in_range = ({2'b00, w_ridx} < C_NUM_REGS);

   // Byte-lane bits of the address carry no meaning for word registers.
   assign w_unused_addr_lsbs = ^{awaddr_q[1:0], s_axi.ARADDR[1:0]};

   assign s_axi.AWREADY = !aw_held_q && !bvalid_q;
   assign s_axi.WREADY  = !w_held_q && !bvalid_q;
   assign s_axi.ARREADY = !rvalid_q;

   assign w_aw_hs = s_axi.AWVALID && s_axi.AWREADY;
   assign w_w_hs  = s_axi.WVALID && s_axi.WREADY;
   assign w_ar_hs = s_axi.ARVALID && s_axi.ARREADY;

   assign s_axi.BVALID = bvalid_q;
   assign s_axi.BRESP  = bresp_q;
   assign s_axi.RVALID = rvalid_q;
   assign s_axi.RRESP  = rresp_q;
   assign s_axi.RDATA  = rdata_q;

   assign regs_o = regs_q;

   // ------------------------------------------------------------------------
   // Write path: capture AW and W independently, commit once both are held.
   // ------------------------------------------------------------------------
   always_comb begin
      wstate_d  = wstate_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      w_commit  = 1'b0;

      case (wstate_q)
         W_IDLE, W_HALF: begin
            if (aw_held_q && w_held_q) begin
               w_commit  = 1'b1;
               bvalid_d  = 1'b1;
               bresp_d   = w_wr_in_range ? C_RESP_OKAY : C_RESP_SLVERR;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               wstate_d  = W_RESP;
            end else begin
               if (w_aw_hs) begin
                  aw_held_d = 1'b1;
                  awaddr_d  = s_axi.AWADDR;
               end
               if (w_w_hs) begin
                  w_held_d = 1'b1;
                  wdata_d  = s_axi.WDATA;
                  wstrb_d  = s_axi.WSTRB;
               end
               wstate_d = (aw_held_d || w_held_d) ? W_HALF : W_IDLE;
            end
         end
         W_RESP: begin
            if (s_axi.BREADY) begin
               bvalid_d = 1'b0;
               wstate_d = W_IDLE;
            end
         end
         default: begin
            wstate_d = W_IDLE;
         end
      endcase
   end

   // Register update with byte strobes; out-of-range commits change nothing.
   always_comb begin
      regs_d = regs_q;
      if (w_commit && w_wr_in_range) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_widx == (ADDR_WIDTH-2)'(i)) begin
               for (int k = 0; k < 4; k++) begin
                  if (wstrb_q[k]) begin
                     regs_d[i][8*k +: 8] = wdata_q[8*k +: 8];
                  end
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read path: data is taken from regs_q, so a write landing on the same
   // edge as the AR handshake is not visible in this response.
   // ------------------------------------------------------------------------
   always_comb begin
      w_rd_word = 32'h0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_ridx == (ADDR_WIDTH-2)'(i)) begin
            w_rd_word = regs_q[i];
         end
      end
   end

   always_comb begin
      rstate_d = rstate_q;
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;

      case (rstate_q)
         R_IDLE: begin
            if (w_ar_hs) begin
               rvalid_d = 1'b1;
               rresp_d  = w_rd_in_range ? C_RESP_OKAY : C_RESP_SLVERR;
               rdata_d  = w_rd_in_range ? w_rd_word : 32'h0;
               rstate_d = R_DATA;
            end
         end
         R_DATA: begin
            if (s_axi.RREADY) begin
               rvalid_d = 1'b0;
               rstate_d = R_IDLE;
            end
         end
         default: begin
            rstate_d = R_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         regs_q    <= '0;
         wstate_q  <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= C_RESP_OKAY;
         rstate_q  <= R_IDLE;
         rvalid_q  <= 1'b0;
         rresp_q   <= C_RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         regs_q    <= regs_d;
         wstate_q  <= wstate_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rstate_q  <= rstate_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_slave_regfile
//  Description : Directed self-checking bench for axi_lite_slave_regfile.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_lite_slave_regfile;

   localparam int AW = 32;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi_lite_slave_regfile_if #(.ADDR_WIDTH(AW)) bus ();
   logic [32*NR-1:0] regs;

   axi_lite_slave_regfile #(
      .ADDR_WIDTH (AW),
      .NUM_REGS   (NR)
   ) dut (
      .ACLK    (clk),
      .ARESETn (rst_n),
      .s_axi   (bus),
      .regs_o  (regs)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done = 0;
      bit w_done  = 0;
      bit aw_fire, w_fire;
      int t = 0;
      bus.AWADDR  = addr;
      bus.AWVALID = 1'b1;
      bus.WDATA   = data;
      bus.WSTRB   = strb;
      bus.WVALID  = 1'b1;
      while (!(aw_done && w_done) && t < 20) begin
         aw_fire = bus.AWVALID && bus.AWREADY;
         w_fire  = bus.WVALID && bus.WREADY;
         tick();
         t++;
         if (aw_fire) begin aw_done = 1; bus.AWVALID = 1'b0; end
         if (w_fire)  begin w_done = 1;  bus.WVALID  = 1'b0; end
      end
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      bus.BREADY  = 1'b1;
      t = 0;
      while (!bus.BVALID && t < 20) begin
         tick();
         t++;
      end
      check_eq({tag, "_bvalid"}, bus.BVALID, 1'b1);
      resp = bus.BRESP;
      tick();
      bus.BREADY = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr,
                          output logic [31:0] data, output logic [1:0] resp);
      bit fire;
      int t = 0;
      bus.ARADDR  = addr;
      bus.ARVALID = 1'b1;
      while (bus.ARVALID && t < 20) begin
         fire = bus.ARREADY;
         tick();
         t++;
         if (fire) bus.ARVALID = 1'b0;
      end
      bus.ARVALID = 1'b0;
      bus.RREADY  = 1'b1;
      t = 0;
      while (!bus.RVALID && t < 20) begin
         tick();
         t++;
      end
      check_eq({tag, "_rvalid"}, bus.RVALID, 1'b1);
      data = bus.RDATA;
      resp = bus.RRESP;
      tick();
      bus.RREADY = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_words [4];
      logic [31:0] rd;
      logic [1:0]  rs;
      logic [32*NR-1:0] saved;

      exp_words[0] = 32'hDEEDBEEF;
      exp_words[1] = 32'hDEEDBEE0;
      exp_words[2] = 32'hDEEDBEE1;
      exp_words[3] = 32'hDEEDBEE2;

      bus.AWADDR = '0; bus.AWVALID = 1'b0;
      bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
      bus.BREADY = 1'b0;
      bus.ARADDR = '0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b0;

      // ---------------- reset state ----------------
      repeat (3) tick();
      check_eq("rst_bvalid", bus.BVALID, 1'b0);
      check_eq("rst_rvalid", bus.RVALID, 1'b0);
      check_eq("rst_bresp", bus.BRESP, 2'b00);
      check_eq("rst_rresp", bus.RRESP, 2'b00);
      check_eq("rst_rdata", bus.RDATA, 32'h0);
      check_eq("rst_regs", regs, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_eq("rst_awready", bus.AWREADY, 1'b1);
      check_eq("rst_wready", bus.WREADY, 1'b1);
      check_eq("rst_arready", bus.ARREADY, 1'b1);

      // ---------------- four full-word writes, then reads ----------------
      for (int i = 0; i < 4; i++) begin
         do_write("wr4", 32'(4*i), exp_words[i], 4'hF, rs);
         check_eq("wr4_bresp", rs, 2'b00);
      end
      for (int i = 0; i < 4; i++) begin
         do_read("rd4", 32'(4*i), rd, rs);
         check_eq("rd4_data", rd, exp_words[i]);
         check_eq("rd4_rresp", rs, 2'b00);
      end
      check_eq("regs_after_wr4", regs, {32'hDEEDBEE2, 32'hDEEDBEE1, 32'hDEEDBEE0, 32'hDEEDBEEF});

      // ---------------- AW three cycles ahead of W ----------------
      bus.AWADDR  = 32'h4;
      bus.AWVALID = 1'b1;
      tick();                           // AW handshake
      bus.AWVALID = 1'b0;
      check_eq("awfirst_awready", bus.AWREADY, 1'b0);
      check_eq("awfirst_wready", bus.WREADY, 1'b1);
      repeat (2) tick();
      check_eq("awfirst_awready_hold", bus.AWREADY, 1'b0);
      check_eq("awfirst_no_bvalid", bus.BVALID, 1'b0);
      bus.WDATA  = 32'h12345678;
      bus.WSTRB  = 4'hF;
      bus.WVALID = 1'b1;
      tick();                           // W handshake
      bus.WVALID = 1'b0;
      check_eq("awfirst_bvalid_at_hs", bus.BVALID, 1'b0);
      tick();                           // commit
      check_eq("awfirst_bvalid_next", bus.BVALID, 1'b1);
      check_eq("awfirst_bresp", bus.BRESP, 2'b00);
      bus.BREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0;
      check_eq("awfirst_bvalid_drop", bus.BVALID, 1'b0);
      do_read("awfirst_rd", 32'h4, rd, rs);
      check_eq("awfirst_rdata", rd, 32'h12345678);

      // ---------------- byte strobes ----------------
      do_write("strb", 32'h0, 32'hAABBCCDD, 4'b0101, rs);
      check_eq("strb_bresp", rs, 2'b00);
      do_read("strb_rd", 32'h0, rd, rs);
      check_eq("strb_rdata", rd, 32'hDEBBBEDD);

      // ---------------- out of range ----------------
      saved = regs;
      do_write("oor", 32'h10, 32'hFFFFFFFF, 4'hF, rs);
      check_eq("oor_bresp", rs, 2'b10);
      check_eq("oor_regs_unchanged", regs, saved);
      do_read("oor_rd", 32'h10, rd, rs);
      check_eq("oor_rresp", rs, 2'b10);
      check_eq("oor_rdata", rd, 32'h0);

      // ---------------- backpressure on B and R ----------------
      bus.AWADDR = 32'h8; bus.AWVALID = 1'b1;
      bus.WDATA = 32'h0BADF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      bus.ARADDR = 32'hC; bus.ARVALID = 1'b1;
      tick();                           // AW, W, AR handshakes
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      check_eq("bp_rvalid_early", bus.RVALID, 1'b1);
      tick();                           // write commit
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_bvalid", bus.BVALID, 1'b1);
         check_eq("bp_bresp", bus.BRESP, 2'b00);
         check_eq("bp_rvalid", bus.RVALID, 1'b1);
         check_eq("bp_rdata", bus.RDATA, 32'hDEEDBEE2);
         check_eq("bp_rresp", bus.RRESP, 2'b00);
         check_eq("bp_awready", bus.AWREADY, 1'b0);
         check_eq("bp_wready", bus.WREADY, 1'b0);
         check_eq("bp_arready", bus.ARREADY, 1'b0);
         tick();
      end
      bus.BREADY = 1'b1; bus.RREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0; bus.RREADY = 1'b0;
      check_eq("bp_bvalid_clr", bus.BVALID, 1'b0);
      check_eq("bp_rvalid_clr", bus.RVALID, 1'b0);
      check_eq("bp_arready_back", bus.ARREADY, 1'b1);
      check_eq("bp_reg2", regs[95:64], 32'h0BADF00D);

      // ---------------- read and write to the same register on one edge ----------------
      bus.AWADDR = 32'h4; bus.AWVALID = 1'b1;
      bus.WDATA = 32'hCAFE0001; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      tick();                           // AW/W handshake
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      bus.ARADDR = 32'h4; bus.ARVALID = 1'b1;
      tick();                           // commit and AR handshake together
      bus.ARVALID = 1'b0;
      check_eq("same_rvalid", bus.RVALID, 1'b1);
      check_eq("same_rdata_old", bus.RDATA, 32'h12345678);
      check_eq("same_reg1_new", regs[63:32], 32'hCAFE0001);
      check_eq("same_bvalid", bus.BVALID, 1'b1);
      bus.BREADY = 1'b1; bus.RREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0; bus.RREADY = 1'b0;
      do_read("same_rd", 32'h4, rd, rs);
      check_eq("same_rdata_new", rd, 32'hCAFE0001);

      // ---------------- reset mid-transaction ----------------
      bus.AWADDR = 32'h0; bus.AWVALID = 1'b1;
      bus.WDATA = 32'h00000055; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      bus.ARADDR = 32'h4; bus.ARVALID = 1'b1;
      tick();
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      tick();
      check_eq("mid_bvalid_pre", bus.BVALID, 1'b1);
      check_eq("mid_rvalid_pre", bus.RVALID, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;                               // still before the next rising edge
      check_eq("mid_bvalid_async", bus.BVALID, 1'b0);
      check_eq("mid_rvalid_async", bus.RVALID, 1'b0);
      check_eq("mid_regs_async", regs, 128'h0);
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      check_eq("mid_no_bvalid_after", bus.BVALID, 1'b0);
      check_eq("mid_no_rvalid_after", bus.RVALID, 1'b0);
      do_read("mid_rd", 32'h0, rd, rs);
      check_eq("mid_rdata", rd, 32'h0);
      check_eq("mid_rresp", rs, 2'b00);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
